// File: rtl/cpu_isa_pkg.sv
// Shared ISA constants for the fetch front-end and instruction memory.
// This package holds the opcode values, the bus widths and the fetch FSM encoding.
package cpu_isa_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  localparam logic [DATA_W-1:0] OP_NOP  = 8'h00;
  localparam logic [DATA_W-1:0] OP_HALT = 8'hFF;

  typedef enum logic [1:0] {
    FETCH_OP   = 2'd0,
    FETCH_OPND = 2'd1,
    HALTED     = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/instr_length_decode.sv
// Classifies an opcode by its length (one or two bytes) and flags HALT.
// The logic is purely combinational so the decoder can reuse it as is.
module instr_length_decode #(
  parameter logic [cpu_isa_pkg::DATA_W-1:0] OP_NOP  = cpu_isa_pkg::OP_NOP,
  parameter logic [cpu_isa_pkg::DATA_W-1:0] OP_HALT = cpu_isa_pkg::OP_HALT
) (
  input  logic [cpu_isa_pkg::DATA_W-1:0] i_opcode,
  output logic                           o_is_one_byte,
  output logic                           o_is_halt
);
  logic w_is_nop;

  assign w_is_nop      = (i_opcode == OP_NOP);
  assign o_is_halt     = (i_opcode == OP_HALT);
  assign o_is_one_byte = w_is_nop || o_is_halt;
endmodule

// File: rtl/instruction_fetch_unit.sv
// Sequential fetch front-end: walks the PC and assembles 1/2-byte instructions.
// Completed instructions go out through a registered valid/ready output stage.
//
//   state      | meaning
//   FETCH_OP   | Data_in is an opcode byte at PC
//   FETCH_OPND | Data_in is the operand byte of the held opcode
//   HALTED     | HALT issued; PC frozen until Redirect or reset
module instruction_fetch_unit #(
  parameter logic [cpu_isa_pkg::ADDR_W-1:0] RESET_PC = 8'h00,
  parameter logic [cpu_isa_pkg::DATA_W-1:0] OP_NOP   = cpu_isa_pkg::OP_NOP,
  parameter logic [cpu_isa_pkg::DATA_W-1:0] OP_HALT  = cpu_isa_pkg::OP_HALT
) (
  input  logic                           Clk,
  input  logic                           Reset_n,
  output logic [cpu_isa_pkg::ADDR_W-1:0] Address,
  input  logic [cpu_isa_pkg::DATA_W-1:0] Data_in,
  output logic                           Instr_valid,
  input  logic                           Instr_ready,
  output logic [cpu_isa_pkg::DATA_W-1:0] Opcode,
  output logic [cpu_isa_pkg::DATA_W-1:0] Operand,
  output logic [cpu_isa_pkg::ADDR_W-1:0] Instr_pc,
  input  logic                           Redirect,
  input  logic [cpu_isa_pkg::ADDR_W-1:0] Redirect_addr,
  output logic                           Halted
);
  import cpu_isa_pkg::*;

  fetch_state_t        r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [DATA_W-1:0]   r_hold_op;
  logic [ADDR_W-1:0]   r_hold_pc;
  logic                r_valid;
  logic [DATA_W-1:0]   r_opcode;
  logic [DATA_W-1:0]   r_operand;
  logic [ADDR_W-1:0]   r_instr_pc;
  logic                r_halted;

  logic                w_can_load;
  logic                w_is_one_byte;
  logic                w_is_halt;
  logic [ADDR_W-1:0]   w_pc_next;

  instr_length_decode #(
    .OP_NOP  (OP_NOP),
    .OP_HALT (OP_HALT)
  ) u_len_dec (
    .i_opcode      (Data_in),
    .o_is_one_byte (w_is_one_byte),
    .o_is_halt     (w_is_halt)
  );

  assign w_can_load = !r_valid || Instr_ready;
  assign w_pc_next  = r_pc + 8'd1;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= FETCH_OP;
      r_pc       <= RESET_PC;
      r_hold_op  <= '0;
      r_hold_pc  <= '0;
      r_valid    <= 1'b0;
      r_opcode   <= '0;
      r_operand  <= '0;
      r_instr_pc <= '0;
      r_halted   <= 1'b0;
    end else if (Redirect) begin
      // A handshake in this cycle already counts as accepted; anything else is dropped.
      r_state  <= FETCH_OP;
      r_pc     <= Redirect_addr;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
    end else if (w_can_load) begin
      case (r_state)
        FETCH_OP: begin
          r_pc <= w_pc_next;
          if (w_is_one_byte) begin
            r_valid    <= 1'b1;
            r_opcode   <= Data_in;
            r_operand  <= '0;
            r_instr_pc <= r_pc;
            if (w_is_halt) begin
              r_state  <= HALTED;
              r_halted <= 1'b1;
            end
          end else begin
            r_hold_op <= Data_in;
            r_hold_pc <= r_pc;
            r_valid   <= 1'b0;
            r_state   <= FETCH_OPND;
          end
        end
        FETCH_OPND: begin
          r_pc       <= w_pc_next;
          r_valid    <= 1'b1;
          r_opcode   <= r_hold_op;
          r_operand  <= Data_in;
          r_instr_pc <= r_hold_pc;
          r_state    <= FETCH_OP;
        end
        default: begin
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign Address     = r_pc;
  assign Instr_valid = r_valid;
  assign Opcode      = r_opcode;
  assign Operand     = r_operand;
  assign Instr_pc    = r_instr_pc;
  assign Halted      = r_halted;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus a
// randomized run scored against an instruction stream parsed from the memory image.
module tb_instruction_fetch_unit;
  logic       clk = 1'b0;
  logic       rst_n, rst2_n;
  logic [7:0] address, data_in, opcode, operand, instr_pc, redirect_addr;
  logic       valid, ready, redirect, halted;
  logic [7:0] address2, data_in2, opcode2, operand2, instr_pc2, redirect_addr2;
  logic       valid2, ready2, redirect2, halted2;
  logic [7:0] mem [256];
  int         checks = 0;
  int         errors = 0;

  typedef struct {
    logic [7:0] pc;
    logic [7:0] op;
    logic [7:0] opnd;
  } instr_t;
  instr_t exp_q[$];

  assign data_in  = mem[address];
  assign data_in2 = mem[address2];

  always #5 clk = ~clk;

  instruction_fetch_unit u_dut (
    .Clk(clk), .Reset_n(rst_n), .Address(address), .Data_in(data_in),
    .Instr_valid(valid), .Instr_ready(ready), .Opcode(opcode), .Operand(operand),
    .Instr_pc(instr_pc), .Redirect(redirect), .Redirect_addr(redirect_addr),
    .Halted(halted)
  );

  instruction_fetch_unit #(.RESET_PC(8'hFF)) u_dut_ff (
    .Clk(clk), .Reset_n(rst2_n), .Address(address2), .Data_in(data_in2),
    .Instr_valid(valid2), .Instr_ready(ready2), .Opcode(opcode2), .Operand(operand2),
    .Instr_pc(instr_pc2), .Redirect(redirect2), .Redirect_addr(redirect_addr2),
    .Halted(halted2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_instr(input string tag, input logic [7:0] pc, input logic [7:0] op,
                           input logic [7:0] opnd);
    chk({tag, "_valid"}, {31'd0, valid}, 32'd1);
    chk(tag, {8'd0, instr_pc, opcode, operand}, {8'd0, pc, op, opnd});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n    = 1'b0;
    ready    = 1'b1;
    redirect = 1'b0;
    redirect_addr = 8'h00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic load_image(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4);
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = b0; mem[1] = b1; mem[2] = b2; mem[3] = b3; mem[4] = b4;
  endtask

  // Reference: walk the image from start, splitting it into instructions by opcode length.
  function automatic void build_stream(input logic [7:0] start);
    logic [7:0] pc;
    logic [7:0] nxt;
    instr_t     t;
    exp_q.delete();
    pc = start;
    for (int n = 0; n < 300; n++) begin
      nxt  = pc + 8'd1;
      t.pc = pc;
      t.op = mem[pc];
      if (t.op == 8'h00 || t.op == 8'hFF) begin
        t.opnd = 8'h00;
        pc     = nxt;
      end else begin
        t.opnd = mem[nxt];
        pc     = nxt + 8'd1;
      end
      exp_q.push_back(t);
      if (t.op == 8'hFF) break;
    end
  endfunction

  initial begin
    logic        hold_prev;
    logic [24:0] snap;
    logic        rd;
    instr_t      e;

    rst_n = 1'b0; rst2_n = 1'b0;
    ready = 1'b1; redirect = 1'b0; redirect_addr = 8'h00;
    ready2 = 1'b1; redirect2 = 1'b0; redirect_addr2 = 8'h00;

    // Scenario 1: basic mixed-length stream
    load_image(8'h00, 8'hC0, 8'h2A, 8'h01, 8'h05);
    #2;
    chk("rst_address", {24'd0, address}, 32'h00);
    chk("rst_valid",   {31'd0, valid},   32'd0);
    chk("rst_halted",  {31'd0, halted},  32'd0);
    chk("rst_outputs", {8'd0, instr_pc, opcode, operand}, 32'd0);
    reset_dut();
    tick(); chk_instr("s1_nop", 8'h00, 8'h00, 8'h00);
    tick(); chk("s1_gap_valid", {31'd0, valid}, 32'd0);
    chk("s1_gap_addr", {24'd0, address}, 32'h02);
    tick(); chk_instr("s1_c0", 8'h01, 8'hC0, 8'h2A);
    tick(); chk("s1_gap2_valid", {31'd0, valid}, 32'd0);
    tick(); chk_instr("s1_01", 8'h03, 8'h01, 8'h05);
    chk("s1_addr_end", {24'd0, address}, 32'h05);

    // Scenario 2: back-pressure freezes outputs and PC
    reset_dut();
    tick(); chk_instr("s2_nop", 8'h00, 8'h00, 8'h00);
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_instr("s2_hold", 8'h00, 8'h00, 8'h00);
      chk("s2_hold_addr", {24'd0, address}, 32'h01);
    end
    ready = 1'b1;
    tick(); chk("s2_latch_valid", {31'd0, valid}, 32'd0);
    chk("s2_latch_addr", {24'd0, address}, 32'h02);
    tick(); chk_instr("s2_c0", 8'h01, 8'hC0, 8'h2A);
    tick(); chk("s2_gap_valid", {31'd0, valid}, 32'd0);
    tick(); chk_instr("s2_01", 8'h03, 8'h01, 8'h05);

    // Scenario 3: redirect while waiting for an operand
    mem[8'h10] = 8'h01; mem[8'h11] = 8'hAB;
    reset_dut();
    tick(); tick();
    chk("s3_pre_addr", {24'd0, address}, 32'h02);
    redirect = 1'b1; redirect_addr = 8'h10;
    tick();
    redirect = 1'b0;
    chk("s3_addr", {24'd0, address}, 32'h10);
    chk("s3_flush_valid", {31'd0, valid}, 32'd0);
    tick(); chk("s3_latch_valid", {31'd0, valid}, 32'd0);
    tick(); chk_instr("s3_target", 8'h10, 8'h01, 8'hAB);

    // Scenario 4: RESET_PC=FF, operand wraps to address 00
    mem[8'hFF] = 8'hC0; mem[8'h00] = 8'h77;
    #1;
    chk("s4_rst_addr", {24'd0, address2}, 32'hFF);
    @(posedge clk); #1; rst2_n = 1'b1;
    tick();
    chk("s4_latch_valid", {31'd0, valid2}, 32'd0);
    chk("s4_wrap_addr", {24'd0, address2}, 32'h00);
    tick();
    chk("s4_valid", {31'd0, valid2}, 32'd1);
    chk("s4_instr", {8'd0, instr_pc2, opcode2, operand2}, {8'd0, 8'hFF, 8'hC0, 8'h77});
    chk("s4_addr_after", {24'd0, address2}, 32'h01);

    // Scenario 5: HALT stops fetch until redirect
    load_image(8'h00, 8'hFF, 8'h00, 8'h00, 8'h00);
    reset_dut();
    tick(); chk_instr("s5_nop", 8'h00, 8'h00, 8'h00);
    tick(); chk_instr("s5_halt", 8'h01, 8'hFF, 8'h00);
    chk("s5_halted", {31'd0, halted}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("s5_idle_valid", {31'd0, valid}, 32'd0);
      chk("s5_idle_addr", {24'd0, address}, 32'h02);
      chk("s5_idle_halted", {31'd0, halted}, 32'd1);
    end
    redirect = 1'b1; redirect_addr = 8'h00;
    tick();
    redirect = 1'b0;
    chk("s5_unhalt", {31'd0, halted}, 32'd0);
    chk("s5_redir_addr", {24'd0, address}, 32'h00);
    tick(); chk_instr("s5_renop", 8'h00, 8'h00, 8'h00);

    // Scenario 6: asynchronous reset mid-cycle with an instruction pending
    reset_dut();
    tick(); tick();
    ready = 1'b0;
    chk_instr("s6_halt", 8'h01, 8'hFF, 8'h00);
    #3;
    rst_n = 1'b0;
    #1;
    chk("s6_valid", {31'd0, valid}, 32'd0);
    chk("s6_addr", {24'd0, address}, 32'h00);
    chk("s6_halted", {31'd0, halted}, 32'd0);
    mem[0] = 8'h01; mem[1] = 8'h05;
    @(posedge clk); #1;
    rst_n = 1'b1; ready = 1'b1;
    tick(); chk("s6_resume_addr", {24'd0, address}, 32'h01);
    tick(); chk_instr("s6_resume", 8'h00, 8'h01, 8'h05);

    // Randomized run with back-pressure and occasional redirects
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    reset_dut();
    build_stream(8'h00);
    hold_prev = 1'b0;
    snap = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (hold_prev)
        chk("rnd_stable", {7'd0, valid, instr_pc, opcode, operand}, {7'd0, snap});
      ready = ($urandom_range(0, 9) < 7);
      rd = ($urandom_range(0, 39) == 0);
      redirect = rd;
      redirect_addr = 8'($urandom);
      if (exp_q.size() == 0) begin
        chk("rnd_no_extra", {31'd0, valid}, 32'd0);
      end else if (valid && ready) begin
        e = exp_q.pop_front();
        chk("rnd_instr", {8'd0, instr_pc, opcode, operand}, {8'd0, e.pc, e.op, e.opnd});
      end
      hold_prev = valid && !ready && !rd;
      snap = {valid, instr_pc, opcode, operand};
      if (rd) build_stream(redirect_addr);
      tick();
    end
    redirect = 1'b0;
    ready = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
